dmem_pipe: RTL and testbench

- Parametrised successor to the single-cycle data RAM.
- Single-port 32-bit data memory for the RISC-V core's MEM stage, with a valid/ready request interface and a configurable read-latency pipeline.
- Clears its contents in a hardware init sequence (BRAM-friendly) and flags out-of-range accesses, plus misaligned accesses when the optional feature is compiled in.
- Keeps the core's existing 3-bit load/store encoding.

---
 rtl/dmem_pkg.sv | 29 ++
 rtl/dmem_load_align.sv | 30 +++
 rtl/dmem_pipe.sv | 160 ++++++++++++++++
 tb/tb_dmem_pipe.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the pipelined data memory: load/store opcodes,
// controller states and the store byte-lane mask helper.
package dmem_pkg;

  localparam logic [2:0] LS_LB  = 3'b000;
  localparam logic [2:0] LS_LBU = 3'b001;
  localparam logic [2:0] LS_LH  = 3'b010;
  localparam logic [2:0] LS_LHU = 3'b011;
  localparam logic [2:0] LS_LW  = 3'b100;
  localparam logic [2:0] LS_SB  = 3'b101;
  localparam logic [2:0] LS_SH  = 3'b110;
  localparam logic [2:0] LS_SW  = 3'b111;

  typedef enum logic {INIT, RUN} state_t;

  // Byte lanes touched by a store; loads produce an empty mask.
  function automatic logic [3:0] write_mask(input logic [2:0] op, input logic [1:0] off);
    logic [3:0] m;
    m = 4'b0000;
    case (op)
      LS_SB:   m = 4'b0001 << off;
      LS_SH:   m = off[1] ? 4'b1100 : 4'b0011;
      LS_SW:   m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Load-data extraction at the pipeline output: selects the addressed byte or
// half of the read word and sign/zero extends it according to the opcode.
module dmem_load_align
  import dmem_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_offset,
  input  logic [2:0]  i_op,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_word[8*i_offset +: 8];
  assign w_half = i_offset[1] ? i_word[31:16] : i_word[15:0];

  always_comb begin
    o_data = 32'h0;
    case (i_op)
      LS_LB:   o_data = {{24{w_byte[7]}}, w_byte};
      LS_LBU:  o_data = {24'h0, w_byte};
      LS_LH:   o_data = {{16{w_half[15]}}, w_half};
      LS_LHU:  o_data = {16'h0, w_half};
      LS_LW:   o_data = i_word;
      default: o_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/dmem_pipe.sv
// Single-port 32-bit data memory with valid/ready requests, hardware clear on
// reset and a READ_LATENCY-deep response pipeline. Define DMEM_ALIGN_CHECK_EN
// to also flag misaligned half/word accesses as errors.
module dmem_pipe
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int DEPTH        = 1024,
  parameter int READ_LATENCY = 1,
  parameter int INIT_ZERO    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  input  logic [2:0]            req_load_store,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic                  init_done
);

  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int WIDX_W = ADDR_WIDTH - 2;
  localparam int LAST   = READ_LATENCY - 1;

  state_t           r_state, w_state_next;
  logic [IDX_W-1:0] r_idx, w_idx_next;

  logic [31:0] r_mem [DEPTH];

  logic [WIDX_W-1:0] w_word_idx;
  logic [IDX_W-1:0]  w_mem_idx;
  logic              w_in_range;
  logic              w_misalign;
  logic              w_err;
  logic              w_accept;
  logic              w_is_store;
  logic [3:0]        w_wmask;
  logic [31:0]       w_wdata_lanes;
  logic [31:0]       w_load_data;

  logic        r_pv    [READ_LATENCY];
  logic [31:0] r_pword [READ_LATENCY];
  logic [1:0]  r_poff  [READ_LATENCY];
  logic [2:0]  r_pop   [READ_LATENCY];
  logic        r_perr  [READ_LATENCY];
  logic        r_pst   [READ_LATENCY];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= (INIT_ZERO != 0) ? INIT : RUN;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
    end
  end

  // Ready/done are masked by rst so the block looks idle while reset is held.
  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    req_ready    = 1'b0;
    init_done    = 1'b0;
    case (r_state)
      INIT: begin
        w_idx_next = r_idx + IDX_W'(1);
        if (r_idx == IDX_W'(DEPTH - 1)) begin
          w_state_next = RUN;
          w_idx_next   = '0;
        end
      end
      RUN: begin
        req_ready = !rst;
        init_done = !rst;
      end
      default: w_state_next = INIT;
    endcase
  end

  assign w_word_idx = req_addr[ADDR_WIDTH-1:2];
  assign w_in_range = (w_word_idx < WIDX_W'(DEPTH));
  assign w_mem_idx  = w_in_range ? w_word_idx[IDX_W-1:0] : '0;
  assign w_accept   = req_valid & req_ready;
  assign w_is_store = (req_load_store == LS_SB) || (req_load_store == LS_SH) ||
                      (req_load_store == LS_SW);
  assign w_wmask    = write_mask(req_load_store, req_addr[1:0]);
  assign w_err      = !w_in_range | w_misalign;

`ifdef DMEM_ALIGN_CHECK_EN
  always_comb begin
    w_misalign = 1'b0;
    case (req_load_store)
      LS_LH, LS_LHU, LS_SH: w_misalign = req_addr[0];
      LS_LW, LS_SW:         w_misalign = |req_addr[1:0];
      default:              w_misalign = 1'b0;
    endcase
  end
`else
  assign w_misalign = 1'b0;
`endif

  // Store data arrives right-aligned; replicate it so every lane sees its bytes.
  always_comb begin
    w_wdata_lanes = req_wdata;
    case (req_load_store)
      LS_SB:   w_wdata_lanes = {4{req_wdata[7:0]}};
      LS_SH:   w_wdata_lanes = {2{req_wdata[15:0]}};
      default: w_wdata_lanes = req_wdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst && r_state == INIT) begin
      r_mem[r_idx] <= 32'h0;
    end else if (w_accept && w_is_store && !w_err) begin
      for (int b = 0; b < 4; b++) begin
        if (w_wmask[b]) r_mem[w_mem_idx][8*b +: 8] <= w_wdata_lanes[8*b +: 8];
      end
    end
    if (w_accept) begin
      r_pword[0] <= r_mem[w_mem_idx];
      r_poff[0]  <= req_addr[1:0];
      r_pop[0]   <= req_load_store;
      r_perr[0]  <= w_err;
      r_pst[0]   <= w_is_store;
    end
    for (int k = 1; k < READ_LATENCY; k++) begin
      r_pword[k] <= r_pword[k-1];
      r_poff[k]  <= r_poff[k-1];
      r_pop[k]   <= r_pop[k-1];
      r_perr[k]  <= r_perr[k-1];
      r_pst[k]   <= r_pst[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < READ_LATENCY; k++) r_pv[k] <= 1'b0;
    end else begin
      r_pv[0] <= w_accept;
      for (int k = 1; k < READ_LATENCY; k++) r_pv[k] <= r_pv[k-1];
    end
  end

  dmem_load_align u_align (
    .i_word   (r_pword[LAST]),
    .i_offset (r_poff[LAST]),
    .i_op     (r_pop[LAST]),
    .o_data   (w_load_data)
  );

  assign rsp_valid = r_pv[LAST];
  assign rsp_err   = r_pv[LAST] & r_perr[LAST];
  assign rsp_rdata = (r_pv[LAST] && !r_perr[LAST] && !r_pst[LAST]) ? w_load_data : 32'h0;

endmodule

// File: tb/tb_dmem_pipe.sv
// Directed bench for dmem_pipe: one DEPTH=16 instance with latency 1 and one
// with latency 3 share the same request stream.
module tb_dmem_pipe;
  import dmem_pkg::*;

  logic        clk;
  logic        rst;
  logic        reqValid;
  logic [31:0] reqAddr;
  logic [31:0] reqWdata;
  logic [2:0]  reqOp;

  logic        ready1, rspValid1, rspErr1, initDone1;
  logic [31:0] rspRdata1;
  logic        ready3, rspValid3, rspErr3, initDone3;
  logic [31:0] rspRdata3;

  int nChecks = 0;
  int nErrors = 0;

  dmem_pipe #(.ADDR_WIDTH(32), .DEPTH(16), .READ_LATENCY(1), .INIT_ZERO(1)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid(reqValid), .req_ready(ready1),
    .req_addr(reqAddr), .req_wdata(reqWdata), .req_load_store(reqOp),
    .rsp_valid(rspValid1), .rsp_rdata(rspRdata1), .rsp_err(rspErr1), .init_done(initDone1)
  );

  dmem_pipe #(.ADDR_WIDTH(32), .DEPTH(16), .READ_LATENCY(3), .INIT_ZERO(1)) u_dut3 (
    .clk(clk), .rst(rst), .req_valid(reqValid), .req_ready(ready3),
    .req_addr(reqAddr), .req_wdata(reqWdata), .req_load_store(reqOp),
    .rsp_valid(rspValid3), .rsp_rdata(rspRdata3), .rsp_err(rspErr3), .init_done(initDone3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic applyStimulus(input logic v, input logic [2:0] op,
                               input logic [31:0] addr, input logic [31:0] wdata);
    reqValid = v;
    reqOp    = op;
    reqAddr  = addr;
    reqWdata = wdata;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nChecks++;
    assert (observed === expected) else begin
      nErrors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic checkRsp1(input string tag, input logic v, input logic [31:0] d, input logic e);
    checkOutput({tag, "/valid1"}, 32'(rspValid1), 32'(v));
    checkOutput({tag, "/rdata1"}, rspRdata1, d);
    checkOutput({tag, "/err1"}, 32'(rspErr1), 32'(e));
  endtask

  task automatic checkRsp3(input string tag, input logic v, input logic [31:0] d, input logic e);
    checkOutput({tag, "/valid3"}, 32'(rspValid3), 32'(v));
    checkOutput({tag, "/rdata3"}, rspRdata3, d);
    checkOutput({tag, "/err3"}, 32'(rspErr3), 32'(e));
  endtask

  // Sixteen INIT cycles with ready low and no responses, then RUN.
  task automatic checkInitWindow(input string tag);
    for (int i = 0; i < 16; i++) begin
      checkOutput({tag, "/ready1"}, 32'(ready1), 32'd0);
      checkOutput({tag, "/done1"}, 32'(initDone1), 32'd0);
      checkOutput({tag, "/valid1"}, 32'(rspValid1), 32'd0);
      checkOutput({tag, "/valid3"}, 32'(rspValid3), 32'd0);
      @(negedge clk);
    end
    applyStimulus(1'b0, LS_LW, 32'h0, 32'h0);
    checkOutput({tag, "/readyRun1"}, 32'(ready1), 32'd1);
    checkOutput({tag, "/doneRun1"}, 32'(initDone1), 32'd1);
    checkOutput({tag, "/readyRun3"}, 32'(ready3), 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, LS_LW, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    checkOutput("rstReady", 32'(ready1), 32'd0);
    checkOutput("rstDone", 32'(initDone1), 32'd0);
    checkRsp1("rst", 1'b0, 32'h0, 1'b0);
    checkRsp3("rst", 1'b0, 32'h0, 1'b0);

    rst = 1'b0;
    applyStimulus(1'b1, LS_SW, 32'h0, 32'hFFFF_FFFF);
    checkInitWindow("init");

    applyStimulus(1'b1, LS_LW, 32'h0, 32'h0);   @(negedge clk); checkRsp1("lw0", 1'b1, 32'h0, 1'b0);
    applyStimulus(1'b1, LS_LW, 32'h3C, 32'h0);  @(negedge clk); checkRsp1("lw3C", 1'b1, 32'h0, 1'b0);

    applyStimulus(1'b1, LS_SW, 32'h8, 32'hDEAD_BEEF); @(negedge clk); checkRsp1("swBeef", 1'b1, 32'h0, 1'b0);
    applyStimulus(1'b1, LS_LB, 32'h8, 32'h0);  @(negedge clk); checkRsp1("lb8", 1'b1, 32'hFFFF_FFEF, 1'b0);
    applyStimulus(1'b1, LS_LBU, 32'hB, 32'h0); @(negedge clk); checkRsp1("lbuB", 1'b1, 32'h0000_00DE, 1'b0);
    applyStimulus(1'b1, LS_LH, 32'hA, 32'h0);  @(negedge clk); checkRsp1("lhA", 1'b1, 32'hFFFF_DEAD, 1'b0);
    applyStimulus(1'b1, LS_LHU, 32'h8, 32'h0); @(negedge clk); checkRsp1("lhu8", 1'b1, 32'h0000_BEEF, 1'b0);

    applyStimulus(1'b1, LS_SW, 32'h4, 32'h1122_3344); @(negedge clk); checkRsp1("sw4", 1'b1, 32'h0, 1'b0);
    applyStimulus(1'b1, LS_SB, 32'h5, 32'h1234_56AA); @(negedge clk); checkRsp1("sb5", 1'b1, 32'h0, 1'b0);
    applyStimulus(1'b1, LS_LW, 32'h4, 32'h0);  @(negedge clk); checkRsp1("rawLw4", 1'b1, 32'h1122_AA44, 1'b0);
    applyStimulus(1'b1, LS_SH, 32'h6, 32'hABCD_5566); @(negedge clk); checkRsp1("sh6", 1'b1, 32'h0, 1'b0);
    applyStimulus(1'b1, LS_LW, 32'h4, 32'h0);  @(negedge clk); checkRsp1("lw4AfterSh", 1'b1, 32'h5566_AA44, 1'b0);

    applyStimulus(1'b1, LS_LW, 32'h40, 32'h0); @(negedge clk); checkRsp1("lwRange", 1'b1, 32'h0, 1'b1);
    applyStimulus(1'b1, LS_SW, 32'h40, 32'h7777_7777); @(negedge clk); checkRsp1("swRange", 1'b1, 32'h0, 1'b1);
    applyStimulus(1'b1, LS_LW, 32'h0, 32'h0);  @(negedge clk); checkRsp1("lw0Unchanged", 1'b1, 32'h0, 1'b0);
    applyStimulus(1'b1, LS_LW, 32'h8000_0000, 32'h0); @(negedge clk); checkRsp1("lwHigh", 1'b1, 32'h0, 1'b1);

`ifdef DMEM_ALIGN_CHECK_EN
    applyStimulus(1'b1, LS_SW, 32'h6, 32'hCAFE_F00D); @(negedge clk); checkRsp1("swMis", 1'b1, 32'h0, 1'b1);
    applyStimulus(1'b1, LS_LW, 32'h4, 32'h0);  @(negedge clk); checkRsp1("lw4AfterMis", 1'b1, 32'h5566_AA44, 1'b0);
    applyStimulus(1'b1, LS_LH, 32'h5, 32'h0);  @(negedge clk); checkRsp1("lhMis", 1'b1, 32'h0, 1'b1);
`else
    applyStimulus(1'b1, LS_SW, 32'h6, 32'hCAFE_F00D); @(negedge clk); checkRsp1("swMis", 1'b1, 32'h0, 1'b0);
    applyStimulus(1'b1, LS_LW, 32'h4, 32'h0);  @(negedge clk); checkRsp1("lw4AfterMis", 1'b1, 32'hCAFE_F00D, 1'b0);
    applyStimulus(1'b1, LS_LH, 32'h5, 32'h0);  @(negedge clk); checkRsp1("lhMis", 1'b1, 32'hFFFF_F00D, 1'b0);
`endif

    applyStimulus(1'b0, LS_LW, 32'h0, 32'h0);
    repeat (4) @(negedge clk);
    checkRsp1("idle", 1'b0, 32'h0, 1'b0);
    checkRsp3("idle", 1'b0, 32'h0, 1'b0);

    // Latency-3 instance: four back-to-back loads, responses two cycles later.
    applyStimulus(1'b1, LS_LW, 32'h8, 32'h0);  @(negedge clk); checkRsp3("rl3Wait1", 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b1, LS_LHU, 32'hA, 32'h0); @(negedge clk); checkRsp3("rl3Wait2", 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b1, LS_LB, 32'hB, 32'h0);  @(negedge clk); checkRsp3("rl3Lw8", 1'b1, 32'hDEAD_BEEF, 1'b0);
    applyStimulus(1'b1, LS_LW, 32'h0, 32'h0);  @(negedge clk); checkRsp3("rl3LhuA", 1'b1, 32'h0000_DEAD, 1'b0);
    applyStimulus(1'b0, LS_LW, 32'h0, 32'h0);  @(negedge clk); checkRsp3("rl3LbB", 1'b1, 32'hFFFF_FFDE, 1'b0);
    @(negedge clk); checkRsp3("rl3Lw0", 1'b1, 32'h0, 1'b0);
    @(negedge clk); checkRsp3("rl3Drain", 1'b0, 32'h0, 1'b0);

    // Reset with two loads in flight in the latency-3 instance.
    applyStimulus(1'b1, LS_LW, 32'h8, 32'h0); @(negedge clk);
    applyStimulus(1'b1, LS_LW, 32'h4, 32'h0); @(negedge clk);
    checkRsp3("preRst", 1'b0, 32'h0, 1'b0);
    rst = 1'b1;
    applyStimulus(1'b0, LS_LW, 32'h0, 32'h0);
    @(negedge clk);
    checkRsp1("midRst", 1'b0, 32'h0, 1'b0);
    checkRsp3("midRst", 1'b0, 32'h0, 1'b0);
    rst = 1'b0;
    checkInitWindow("reinit");

    applyStimulus(1'b1, LS_LW, 32'h8, 32'h0); @(negedge clk); checkRsp1("postRstLw8", 1'b1, 32'h0, 1'b0);
    applyStimulus(1'b1, LS_LW, 32'h4, 32'h0); @(negedge clk); checkRsp1("postRstLw4", 1'b1, 32'h0, 1'b0);
    applyStimulus(1'b0, LS_LW, 32'h0, 32'h0); @(negedge clk); checkRsp3("postRstLw8", 1'b1, 32'h0, 1'b0);
    @(negedge clk); checkRsp3("postRstLw4", 1'b1, 32'h0, 1'b0);
    @(negedge clk); checkRsp3("postRstIdle", 1'b0, 32'h0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
